// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : Shared types and constants for the IEEE 1149.1 TAP
//                controller and its downstream IR/DR consumers.
//                  tap_ctrl_fsm_t   - 16-state TAP state encoding (TLR = 0)
//                  TMS_RESET_CYCLES - tms=1 edges that always reach TLR
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_ctrl_fsm_t;

  localparam int TMS_RESET_CYCLES = 5;

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tap_controller
//  Description : IEEE 1149.1 TAP controller. Advances the 16-state TAP FSM
//                on each tck rising edge from tms, decodes one-hot state
//                strobes for the IR and DR chain, and runs a TMS-high
//                watchdog that cross-checks the 5-clock reset guarantee.
//  Build macro : TAP_STATS_EN - adds UPDATE_DR / UPDATE_IR entry counters
//  Ports       :
//    tck         in   TAP clock, all state changes on rising edge
//    trst        in   synchronous active-high reset (priority over tms)
//    tms         in   test mode select
//    tap_state   out  registered current state (tap_ctrl_fsm_t)
//    tlr .. update_ir  out  one-hot decodes of tap_state
//    upd_dr_cnt  out  UPDATE_DR entries, wraps   (TAP_STATS_EN only)
//    upd_ir_cnt  out  UPDATE_IR entries, wraps   (TAP_STATS_EN only)
//    fsm_err     out  sticky watchdog error, cleared only by trst
//  Parameters  :
//    CNT_W       width of the update counters, legal range 4..32
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_controller
  import jtag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  output tap_ctrl_fsm_t        tap_state,
  output logic                 tlr,
  output logic                 run_idle,
  output logic                 capture_dr,
  output logic                 shift_dr,
  output logic                 update_dr,
  output logic                 capture_ir,
  output logic                 shift_ir,
  output logic                 update_ir,
`ifdef TAP_STATS_EN
  output logic [CNT_W-1:0]     upd_dr_cnt,
  output logic [CNT_W-1:0]     upd_ir_cnt,
`endif
  output logic                 fsm_err
);

  localparam logic [2:0] TMS_HI_MAX = 3'(TMS_RESET_CYCLES);

  generate
    if (CNT_W < 4 || CNT_W > 32) begin : g_cnt_w_check
      $error("tap_controller: CNT_W must be in 4..32");
    end
  endgenerate

  tap_ctrl_fsm_t state_q, state_d;
  logic [2:0]    tms_hi_cnt_q, tms_hi_cnt_d;
  logic          fsm_err_q, fsm_err_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = TEST_LOGIC_RESET;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // --------------------------------------------------------------------------
  // Watchdog: consecutive tms=1 count saturating at TMS_RESET_CYCLES.
  // Once the registered count reaches the limit the registered state must
  // already be TLR; anything else is a broken transition table.
  // --------------------------------------------------------------------------
  always_comb begin
    tms_hi_cnt_d = 3'd0;
    if (tms) begin
      tms_hi_cnt_d = (tms_hi_cnt_q == TMS_HI_MAX) ? tms_hi_cnt_q
                                                  : tms_hi_cnt_q + 3'd1;
    end
    fsm_err_d = fsm_err_q |
                ((tms_hi_cnt_q == TMS_HI_MAX) && (state_q != TEST_LOGIC_RESET));
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q      <= TEST_LOGIC_RESET;
      tms_hi_cnt_q <= 3'd0;
      fsm_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tms_hi_cnt_q <= tms_hi_cnt_d;
      fsm_err_q    <= fsm_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional update-entry counters
  // --------------------------------------------------------------------------
`ifdef TAP_STATS_EN
  logic [CNT_W-1:0] upd_dr_cnt_q, upd_dr_cnt_d;
  logic [CNT_W-1:0] upd_ir_cnt_q, upd_ir_cnt_d;

  always_comb begin
    upd_dr_cnt_d = upd_dr_cnt_q;
    upd_ir_cnt_d = upd_ir_cnt_q;
    if ((state_d == UPDATE_DR) && (state_q != UPDATE_DR)) begin
      upd_dr_cnt_d = upd_dr_cnt_q + 1'b1;
    end
    if ((state_d == UPDATE_IR) && (state_q != UPDATE_IR)) begin
      upd_ir_cnt_d = upd_ir_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      upd_dr_cnt_q <= '0;
      upd_ir_cnt_q <= '0;
    end else begin
      upd_dr_cnt_q <= upd_dr_cnt_d;
      upd_ir_cnt_q <= upd_ir_cnt_d;
    end
  end

  assign upd_dr_cnt = upd_dr_cnt_q;
  assign upd_ir_cnt = upd_ir_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs: strobes decode the state register only, so they are glitch-free
  // with respect to tms and carry no extra latency.
  // --------------------------------------------------------------------------
  assign tap_state  = state_q;
  assign tlr        = (state_q == TEST_LOGIC_RESET);
  assign run_idle   = (state_q == RUN_TEST_IDLE);
  assign capture_dr = (state_q == CAPTURE_DR);
  assign shift_dr   = (state_q == SHIFT_DR);
  assign update_dr  = (state_q == UPDATE_DR);
  assign capture_ir = (state_q == CAPTURE_IR);
  assign shift_ir   = (state_q == SHIFT_IR);
  assign update_ir  = (state_q == UPDATE_IR);
  assign fsm_err    = fsm_err_q;

endmodule : tap_controller
`default_nettype wire
